// File: rtl/tt_ctrl_seq.sv
// tt_ctrl_seq: break-before-make user-design select controller driving N_SIDES spines.
// Define TT_CTRL_SEL_LOAD_EN to add a direct select-load port.
module tt_ctrl_seq #(
    parameter int SEL_W       = 10,
    parameter int SIDE_LSB    = 5,
    parameter int SIDE_W      = 1,
    parameter int SYNC_STAGES = 2,
    parameter int GUARD_CYC   = 4,
    localparam int N_SIDES    = 2 ** SIDE_W
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      ctrl_sel_inc,
    input  logic                      ctrl_ena,
`ifdef TT_CTRL_SEL_LOAD_EN
    input  logic                      sel_load_valid,
    input  logic [SEL_W-1:0]          sel_load_data,
    output logic                      sel_load_ready,
`endif
    output logic [SEL_W-SIDE_W-1:0]   sel,
    output logic [SIDE_W-1:0]         side_sel,
    output logic [N_SIDES-1:0]        side_ena,
    output logic [N_SIDES-1:0]        spine_ena,
    output logic                      busy,
    output logic                      ovf
);
    localparam int TW = $clog2(GUARD_CYC + 1);
    localparam logic [TW-1:0] G_LAST = TW'(GUARD_CYC - 1);

    typedef enum logic [1:0] {RUN, DRAIN, UPDATE, SETTLE} state_t;

    state_t state, state_n;
    logic [SYNC_STAGES-1:0] inc_sync, ena_sync;
    logic inc_prev, inc_req;
    logic [TW-1:0] tmr, tmr_n;
    logic [SEL_W-1:0] cnt, cnt_n;
    logic [1:0] pend, pend_n;
    logic ovf_n;
`ifdef TT_CTRL_SEL_LOAD_EN
    logic ld_flag, ld_flag_n;
    logic [SEL_W-1:0] ld_data;
    logic ld_go;
    assign sel_load_ready = (state == RUN) && (pend == 2'd0) && !inc_req;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inc_sync <= '0;
            ena_sync <= '0;
            inc_prev <= 1'b0;
            inc_req  <= 1'b0;
            state    <= RUN;
            tmr      <= '0;
            cnt      <= '0;
            pend     <= '0;
            ovf      <= 1'b0;
        end else begin
            inc_sync <= {inc_sync[SYNC_STAGES-2:0], ctrl_sel_inc};
            ena_sync <= {ena_sync[SYNC_STAGES-2:0], ctrl_ena};
            inc_prev <= inc_sync[SYNC_STAGES-1];
            inc_req  <= inc_sync[SYNC_STAGES-1] & ~inc_prev;
            state    <= state_n;
            tmr      <= tmr_n;
            cnt      <= cnt_n;
            pend     <= pend_n;
            ovf      <= ovf_n;
        end
    end

`ifdef TT_CTRL_SEL_LOAD_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ld_flag <= 1'b0;
            ld_data <= '0;
        end else begin
            ld_flag <= ld_flag_n;
            if (ld_go) ld_data <= sel_load_data;
        end
    end
`endif

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pend_n  = pend;
        ovf_n   = ovf;
`ifdef TT_CTRL_SEL_LOAD_EN
        ld_go     = 1'b0;
        ld_flag_n = ld_flag;
`endif
        case (state)
            RUN: begin
                // A queued request takes the slot; a new edge this cycle replaces it in the queue.
                if (pend != 2'd0) begin
                    state_n = DRAIN;
                    pend_n  = inc_req ? pend : pend - 2'd1;
                end else if (inc_req) begin
                    state_n = DRAIN;
`ifdef TT_CTRL_SEL_LOAD_EN
                end else if (sel_load_valid && sel_load_ready) begin
                    state_n   = DRAIN;
                    ld_go     = 1'b1;
                    ld_flag_n = 1'b1;
`endif
                end
            end
            DRAIN:  state_n = (tmr == G_LAST) ? UPDATE : DRAIN;
            UPDATE: begin
                state_n = SETTLE;
`ifdef TT_CTRL_SEL_LOAD_EN
                cnt_n     = ld_flag ? ld_data : cnt + 1'b1;
                ld_flag_n = 1'b0;
`else
                cnt_n = cnt + 1'b1;
`endif
            end
            SETTLE: state_n = (tmr == G_LAST) ? RUN : SETTLE;
        endcase
        if (state != RUN && inc_req) begin
            if (pend == 2'd3) ovf_n = 1'b1;
            else pend_n = pend + 2'd1;
        end
        tmr_n = (state_n == state && state != RUN) ? tmr + 1'b1 : '0;
    end

    assign sel       = {cnt[SEL_W-1:SIDE_LSB+SIDE_W], cnt[SIDE_LSB-1:0]};
    assign side_sel  = cnt[SIDE_LSB+:SIDE_W];
    assign side_ena  = N_SIDES'(1) << side_sel;
    assign busy      = (state != RUN);
    assign spine_ena = side_ena & {N_SIDES{ena_sync[SYNC_STAGES-1] && state == RUN}};
endmodule

// File: tb/tb_tt_ctrl_seq.sv
// tb_tt_ctrl_seq: directed vectors and multi-cycle sequences for tt_ctrl_seq (default parameters).
module tb_tt_ctrl_seq;
    logic clk = 1'b0, rst_n = 1'b1, ctrl_sel_inc = 1'b0, ctrl_ena = 1'b0;
    logic [8:0] sel;
    logic       side_sel;
    logic [1:0] side_ena, spine_ena;
    logic       busy, ovf;
`ifdef TT_CTRL_SEL_LOAD_EN
    logic       sel_load_valid = 1'b0;
    logic [9:0] sel_load_data = '0;
    logic       sel_load_ready;
`endif
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    tt_ctrl_seq dut (
        .clk(clk), .rst_n(rst_n), .ctrl_sel_inc(ctrl_sel_inc), .ctrl_ena(ctrl_ena),
`ifdef TT_CTRL_SEL_LOAD_EN
        .sel_load_valid(sel_load_valid), .sel_load_data(sel_load_data), .sel_load_ready(sel_load_ready),
`endif
        .sel(sel), .side_sel(side_sel), .side_ena(side_ena), .spine_ena(spine_ena),
        .busy(busy), .ovf(ovf)
    );

    typedef struct {
        int         n;
        logic [8:0] sel;
        logic       side;
        logic [1:0] sena;
        logic [1:0] spena;
    } vec_t;
    vec_t tv[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s timeout at %0t", nm, $time);
    endtask

    task automatic do_inc();
        int t;
        ctrl_sel_inc = 1'b1;
        tick();
        ctrl_sel_inc = 1'b0;
        t = 0;
        while (!busy && t < 20) begin tick(); t++; end
        if (!busy) timeout("inc_start");
        t = 0;
        while (busy && t < 40) begin tick(); t++; end
        if (busy) timeout("inc_end");
    endtask

    task automatic wait_idle(input int limit, output int seqs);
        int quiet, t;
        logic pb;
        quiet = 0; t = 0; pb = busy; seqs = 0;
        while (quiet < 4 && t < limit) begin
            tick();
            t++;
            if (busy && !pb) seqs++;
            pb = busy;
            quiet = busy ? 0 : quiet + 1;
        end
        if (quiet < 4) timeout("idle");
    endtask

    task automatic restart();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ctrl_ena = 1'b1;
        repeat (5) tick();
    endtask

    initial begin
        int s;
        logic seen;
        tv[0] = '{30,  9'd31,  1'b0, 2'b01, 2'b01};
        tv[1] = '{1,   9'd0,   1'b1, 2'b10, 2'b10};
        tv[2] = '{1,   9'd1,   1'b1, 2'b10, 2'b10};
        tv[3] = '{31,  9'h020, 1'b0, 2'b01, 2'b01};
        tv[4] = '{959, 9'h1FF, 1'b1, 2'b10, 2'b10};
        tv[5] = '{1,   9'd0,   1'b0, 2'b01, 2'b01};

        // reset applied before any clock edge
        #2 rst_n = 1'b0;
        #2;
        chk("rst_sel", sel, 0);
        chk("rst_side_sel", side_sel, 0);
        chk("rst_side_ena", side_ena, 2'b01);
        chk("rst_spine_ena", spine_ena, 2'b00);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);
        tick();
        rst_n = 1'b1;
        ctrl_ena = 1'b1;
        repeat (5) tick();
        chk("idle_spine_ena", spine_ena, 2'b01);

        // single increment, edge by edge
        ctrl_sel_inc = 1'b1;
        for (int e = 0; e <= 13; e++) begin
            tick();
            ctrl_sel_inc = 1'b0;
            chk($sformatf("single_busy_e%0d", e), busy, (e >= 3 && e <= 11) ? 1 : 0);
            chk($sformatf("single_sel_e%0d", e), sel, (e >= 8) ? 1 : 0);
            chk($sformatf("single_spine_e%0d", e), spine_ena, (e >= 3 && e <= 11) ? 2'b00 : 2'b01);
        end

        // side switch and wrap, cumulative from cnt=1
        for (int i = 0; i < 6; i++) begin
            repeat (tv[i].n) do_inc();
            chk($sformatf("vec%0d_sel", i), sel, tv[i].sel);
            chk($sformatf("vec%0d_side_sel", i), side_sel, tv[i].side);
            chk($sformatf("vec%0d_side_ena", i), side_ena, tv[i].sena);
            chk($sformatf("vec%0d_spine_ena", i), spine_ena, tv[i].spena);
        end

        // queueing: five edges two cycles apart, pend saturates, fifth dropped
        restart();
        for (int e = 0; e <= 11; e++) begin
            ctrl_sel_inc = (e <= 8 && e % 2 == 0);
            tick();
            if (e == 3) chk("q_busy_e3", busy, 1);
            if (e == 10) chk("q_ovf_e10", ovf, 0);
            if (e == 11) chk("q_ovf_e11", ovf, 1);
        end
        ctrl_sel_inc = 1'b0;
        wait_idle(300, s);
        chk("q_extra_seqs", s, 3);
        chk("q_sel", sel, 4);
        chk("q_ovf_sticky", ovf, 1);

        // enable fall and rise in RUN
        ctrl_ena = 1'b0;
        tick();
        chk("ena_fall_e0", spine_ena, 2'b01);
        tick();
        chk("ena_fall_e1", spine_ena, 2'b00);
        ctrl_ena = 1'b1;
        tick();
        tick();
        chk("ena_rise", spine_ena, 2'b01);

        // async reset during SETTLE with a queued request
        for (int e = 0; e <= 9; e++) begin
            ctrl_sel_inc = (e == 0 || e == 2);
            tick();
        end
        ctrl_sel_inc = 1'b0;
        chk("settle_busy", busy, 1);
        chk("settle_sel", sel, 5);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sel", sel, 0);
        chk("mid_rst_side_ena", side_ena, 2'b01);
        chk("mid_rst_spine", spine_ena, 2'b00);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ovf", ovf, 0);
        #1 rst_n = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (busy) seen = 1'b1;
        end
        chk("post_rst_no_seq", seen, 0);
        chk("post_rst_sel", sel, 0);
        chk("post_rst_spine", spine_ena, 2'b01);

`ifdef TT_CTRL_SEL_LOAD_EN
        // load with an increment racing it
        restart();
        chk("ld_ready_idle", sel_load_ready, 1);
        sel_load_valid = 1'b1;
        sel_load_data = 10'h3FF;
        ctrl_sel_inc = 1'b1;
        tick();
        sel_load_valid = 1'b0;
        ctrl_sel_inc = 1'b0;
        chk("ld_ready_drop", sel_load_ready, 0);
        chk("ld_busy", busy, 1);
        repeat (5) tick();
        chk("ld_sel", sel, 9'h1FF);
        chk("ld_side_sel", side_sel, 1);
        wait_idle(200, s);
        chk("ld_wrap_sel", sel, 0);
        chk("ld_wrap_side", side_sel, 0);
        chk("ld_ready_back", sel_load_ready, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
